hyperbus_tf_arbiter: RTL and testbench



---
 rtl/hyperbus_tf_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_hyperbus_tf_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_tf_arbiter.sv
// Grants one requester at a time the shared HyperBus trans/TX/RX/B path and locks it for a whole transaction.
// Define HYPERBUS_ARB_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.
package hyperbus_pkg;
  typedef struct packed {
    logic        write;
    logic        addr_space;
    logic        burst_type;
    logic [31:0] address;
    logic [15:0] burst;
  } hyper_tf_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  strb;
  } hyper_tx_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        error;
  } hyper_rx_t;
endpackage

module hyperbus_tf_arbiter #(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned NumChips = 2,
  parameter type hyper_tx_t = hyperbus_pkg::hyper_tx_t,
  parameter type hyper_rx_t = hyperbus_pkg::hyper_rx_t
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  hyperbus_pkg::hyper_tf_t       req_trans_i       [NumReq],
  input  logic [NumChips-1:0]           req_cs_i          [NumReq],
  input  logic [NumReq-1:0]             req_trans_valid_i,
  output logic [NumReq-1:0]             req_trans_ready_o,
  input  hyper_tx_t                     req_tx_i          [NumReq],
  input  logic [NumReq-1:0]             req_tx_valid_i,
  output logic [NumReq-1:0]             req_tx_ready_o,
  output hyper_rx_t                     req_rx_o          [NumReq],
  output logic [NumReq-1:0]             req_rx_valid_o,
  input  logic [NumReq-1:0]             req_rx_ready_i,
  output logic [NumReq-1:0]             req_b_error_o,
  output logic [NumReq-1:0]             req_b_valid_o,
  input  logic [NumReq-1:0]             req_b_ready_i,
  output hyperbus_pkg::hyper_tf_t       trans_o,
  output logic [NumChips-1:0]           trans_cs_o,
  output logic                          trans_valid_o,
  input  logic                          trans_ready_i,
  output hyper_tx_t                     tx_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  input  hyper_rx_t                     rx_i,
  input  logic                          rx_valid_i,
  output logic                          rx_ready_o,
  input  logic                          b_error_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  output logic [$clog2(NumReq)-1:0]     grant_o,
  output logic                          busy_o
);

  localparam int unsigned GntW = $clog2(NumReq);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WDATA,
    WRESP,
    RDATA
  } state_t;

  state_t                  state_q, state_d;
  logic [GntW-1:0]         grant_q;
  logic [GntW-1:0]         winner;
  logic [GntW-1:0]         search_base;
  logic                    accept;
  hyperbus_pkg::hyper_tf_t trans_p0;
  logic [NumChips-1:0]     cs_p0;

  // Accepting is suppressed during reset so no requester sees a handshake that is then discarded.
  assign accept = (state_q == IDLE) && (|req_trans_valid_i) && !rst_i;

`ifdef HYPERBUS_ARB_RR_EN
  logic [GntW-1:0] rr_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (32'(winner) == NumReq - 1) ? '0 : winner + 1'b1;
    end
  end

  assign search_base = rr_ptr;
`else
  assign search_base = '0;
`endif

  // First valid requester at or after search_base, wrapping modulo NumReq.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(search_base) + k) % NumReq;
      if (!found && req_trans_valid_i[idx]) begin
        winner = GntW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      trans_p0 <= '0;
      cs_p0    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q  <= winner;
        trans_p0 <= req_trans_i[winner];
        cs_p0    <= req_cs_i[winner];
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    req_trans_ready_o = '0;
    req_tx_ready_o    = '0;
    req_rx_valid_o    = '0;
    req_b_valid_o     = '0;
    trans_valid_o     = 1'b0;
    tx_o              = '0;
    tx_valid_o        = 1'b0;
    rx_ready_o        = 1'b0;
    b_ready_o         = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      req_rx_o[k]      = rx_i;
      req_b_error_o[k] = b_error_i;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_trans_ready_o[winner] = 1'b1;
          state_d                   = ISSUE;
        end
      end
      ISSUE: begin
        trans_valid_o = 1'b1;
        if (trans_ready_i) begin
          state_d = trans_p0.write ? WDATA : RDATA;
        end
      end
      WDATA: begin
        tx_o                    = req_tx_i[grant_q];
        tx_valid_o              = req_tx_valid_i[grant_q];
        req_tx_ready_o[grant_q] = tx_ready_i;
        if (tx_valid_o && tx_ready_i && tx_o.last) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        req_b_valid_o[grant_q] = b_valid_i;
        b_ready_o              = req_b_ready_i[grant_q];
        if (b_valid_i && b_ready_o) begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        req_rx_valid_o[grant_q] = rx_valid_i;
        rx_ready_o              = req_rx_ready_i[grant_q];
        if (rx_valid_i && rx_ready_o && rx_i.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign trans_o    = trans_p0;
  assign trans_cs_o = cs_p0;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_hyperbus_tf_arbiter.sv
// Scoreboard bench for hyperbus_tf_arbiter with two requesters; expected contention order follows HYPERBUS_ARB_RR_EN.
module tb_hyperbus_tf_arbiter;
  import hyperbus_pkg::*;

  localparam int NR = 2;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              rst;
  hyper_tf_t         req_trans [NR];
  logic [NC-1:0]     req_cs    [NR];
  logic [NR-1:0]     req_trans_valid, req_trans_ready;
  hyper_tx_t         req_tx    [NR];
  logic [NR-1:0]     req_tx_valid, req_tx_ready;
  hyper_rx_t         req_rx    [NR];
  logic [NR-1:0]     req_rx_valid, req_rx_ready;
  logic [NR-1:0]     req_b_error, req_b_valid, req_b_ready;
  hyper_tf_t         trans;
  logic [NC-1:0]     trans_cs;
  logic              trans_valid, trans_ready;
  hyper_tx_t         tx;
  logic              tx_valid, tx_ready;
  hyper_rx_t         rx;
  logic              rx_valid, rx_ready;
  logic              b_error, b_valid, b_ready;
  logic [0:0]        grant;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  hyper_rx_t  exp_rx_q  [$];
  hyper_tx_t  exp_tx_q  [$];
  logic [0:0] exp_gnt_q [$];

  hyperbus_tf_arbiter #(.NumReq(NR), .NumChips(NC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_trans_i(req_trans), .req_cs_i(req_cs),
    .req_trans_valid_i(req_trans_valid), .req_trans_ready_o(req_trans_ready),
    .req_tx_i(req_tx), .req_tx_valid_i(req_tx_valid), .req_tx_ready_o(req_tx_ready),
    .req_rx_o(req_rx), .req_rx_valid_o(req_rx_valid), .req_rx_ready_i(req_rx_ready),
    .req_b_error_o(req_b_error), .req_b_valid_o(req_b_valid), .req_b_ready_i(req_b_ready),
    .trans_o(trans), .trans_cs_o(trans_cs), .trans_valid_o(trans_valid), .trans_ready_i(trans_ready),
    .tx_o(tx), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .rx_i(rx), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .b_error_i(b_error), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .grant_o(grant), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic hyper_tf_t mk_tf(input logic w, input logic [31:0] a);
    hyper_tf_t t;
    t = '0;
    t.write   = w;
    t.address = a;
    t.burst   = 16'd4;
    return t;
  endfunction

  function automatic hyper_rx_t mk_rx(input logic [15:0] d, input logic l, input logic e);
    hyper_rx_t r;
    r.data = d; r.last = l; r.error = e;
    return r;
  endfunction

  function automatic hyper_tx_t mk_tx(input logic [15:0] d, input logic l, input logic [1:0] s);
    hyper_tx_t t;
    t.data = d; t.last = l; t.strb = s;
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_trans[0] = mk_tf(1'b1, 32'h1234);
    req_trans_valid = 2'b11;
    req_tx_valid = 2'b11;
    cyc(); cyc();
    checks++;
    if (req_trans_ready !== 2'b00) begin
      failures++; $display("FAIL rst_trans_ready got=%b want=00", req_trans_ready);
    end
    checks++;
    if ({busy, grant, trans_valid, tx_valid, rx_ready, b_ready} !== 6'b0) begin
      failures++; $display("FAIL rst_ctrl got=%b want=000000", {busy, grant, trans_valid, tx_valid, rx_ready, b_ready});
    end
    checks++;
    if ({req_tx_ready, req_rx_valid, req_b_valid} !== 6'b0) begin
      failures++; $display("FAIL rst_req_hs got=%b want=000000", {req_tx_ready, req_rx_valid, req_b_valid});
    end
    checks++;
    if ({trans, trans_cs, tx} !== '0) begin
      failures++; $display("FAIL rst_data got=%h want=0", {trans, trans_cs, tx});
    end
    req_trans_valid = '0;
    req_tx_valid = '0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_read();
    hyper_tf_t t;
    hyper_rx_t e;
    t = mk_tf(1'b0, 32'h0000_0100);
    req_trans[0] = t; req_cs[0] = 2'b01; req_trans_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_trans_ready !== 2'b01) begin
      failures++; $display("FAIL rd_accept got=%b want=01", req_trans_ready);
    end
    cyc();
    req_trans_valid[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) trans_ready = 1'b1;
      #1;
      checks++;
      if (trans_valid !== 1'b1) begin
        failures++; $display("FAIL rd_issue_valid cycle=%0d got=%b want=1", c, trans_valid);
      end
      if (c == 1) begin
        checks++;
        if ({trans, trans_cs, grant, busy} !== {t, 2'b01, 1'b0, 1'b1}) begin
          failures++; $display("FAIL rd_issue_regs got=%h want=%h", {trans, trans_cs, grant, busy}, {t, 2'b01, 1'b0, 1'b1});
        end
      end
      cyc();
    end
    trans_ready = 1'b0;
    #1;
    checks++;
    if (trans_valid !== 1'b0) begin
      failures++; $display("FAIL rd_issue_drop got=%b want=0", trans_valid);
    end
    req_rx_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      rx = mk_rx(16'hA000 + 16'(i), i == 3, 1'b0);
      exp_rx_q.push_back(rx);
      rx_valid = 1'b1;
      #1;
      checks++;
      if ({req_rx_valid, rx_ready} !== 3'b011) begin
        failures++; $display("FAIL rd_beat_hs beat=%0d got=%b want=011", i, {req_rx_valid, rx_ready});
      end
      e = exp_rx_q.pop_front();
      checks++;
      if (req_rx[0] !== e) begin
        failures++; $display("FAIL rd_beat_data beat=%0d got=%h want=%h", i, req_rx[0], e);
      end
      cyc();
    end
    rx_valid = 1'b0;
    req_rx_ready = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rd_busy_fall got=%b want=0", busy);
    end
  endtask

  task automatic test_write_bp();
    hyper_tf_t t;
    hyper_tx_t beats [2];
    hyper_tx_t e;
    int idx;
    t = mk_tf(1'b1, 32'h0000_0200);
    beats[0] = mk_tx(16'hBEE0, 1'b0, 2'b11);
    beats[1] = mk_tx(16'hBEE1, 1'b1, 2'b01);
    exp_tx_q.push_back(beats[0]);
    exp_tx_q.push_back(beats[1]);
    req_trans[1] = t; req_cs[1] = 2'b10; req_trans_valid[1] = 1'b1;
    req_tx[0] = mk_tx(16'hDEAD, 1'b1, 2'b11); req_tx_valid[0] = 1'b1;
    #1;
    checks++;
    if (req_trans_ready !== 2'b10) begin
      failures++; $display("FAIL wr_accept got=%b want=10", req_trans_ready);
    end
    cyc();
    req_trans_valid[1] = 1'b0;
    trans_ready = 1'b1;
    #1;
    checks++;
    if ({trans_valid, grant, trans_cs, req_tx_ready} !== {1'b1, 1'b1, 2'b10, 2'b00}) begin
      failures++; $display("FAIL wr_issue got=%b want=111000", {trans_valid, grant, trans_cs, req_tx_ready});
    end
    cyc();
    trans_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12 && idx < 2; c++) begin
      req_tx[1] = beats[idx];
      req_tx_valid[1] = 1'b1;
      tx_ready = ((c % 2) == 1);
      #1;
      e = (exp_tx_q.size() > 0) ? exp_tx_q[0] : '0;
      checks++;
      if ({tx_valid, tx} !== {1'b1, e}) begin
        failures++; $display("FAIL wr_beat cycle=%0d got=%h want=%h", c, {tx_valid, tx}, {1'b1, e});
      end
      checks++;
      if (req_tx_ready !== {tx_ready, 1'b0}) begin
        failures++; $display("FAIL wr_tx_ready cycle=%0d got=%b want=%b", c, req_tx_ready, {tx_ready, 1'b0});
      end
      if (tx_ready) begin
        void'(exp_tx_q.pop_front());
        idx++;
      end
      cyc();
    end
    checks++;
    if (idx !== 2) begin
      failures++; $display("FAIL wr_beats_done got=%0d want=2", idx);
    end
    req_tx_valid = '0;
    tx_ready = 1'b0;
    b_valid = 1'b1; b_error = 1'b1; req_b_ready = 2'b10;
    #1;
    checks++;
    if ({req_b_valid, req_b_error[1], b_ready, req_tx_ready} !== {2'b10, 1'b1, 1'b1, 2'b00}) begin
      failures++; $display("FAIL wr_bresp got=%b want=101100", {req_b_valid, req_b_error[1], b_ready, req_tx_ready});
    end
    cyc();
    b_valid = 1'b0; b_error = 1'b0; req_b_ready = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL wr_busy_fall got=%b want=0", busy);
    end
  endtask

  task automatic test_blocking();
    hyper_tf_t t1;
    hyper_rx_t e;
    t1 = mk_tf(1'b0, 32'h0000_0400);
    req_trans[0] = mk_tf(1'b0, 32'h0000_0300); req_cs[0] = 2'b01;
    req_trans_valid = 2'b01;
    #1;
    cyc();
    req_trans[1] = t1; req_cs[1] = 2'b10;
    req_trans_valid = 2'b10;
    trans_ready = 1'b1;
    #1;
    checks++;
    if (req_trans_ready !== 2'b00) begin
      failures++; $display("FAIL blk_issue_ready got=%b want=00", req_trans_ready);
    end
    cyc();
    trans_ready = 1'b0;
    req_rx_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      rx = mk_rx(16'hC000 + 16'(i), i == 1, 1'b0);
      exp_rx_q.push_back(rx);
      rx_valid = 1'b1;
      #1;
      e = exp_rx_q.pop_front();
      checks++;
      if ({req_trans_ready, req_rx_valid, req_rx[0]} !== {2'b00, 2'b01, e}) begin
        failures++; $display("FAIL blk_rdata beat=%0d got=%h want=%h", i, {req_trans_ready, req_rx_valid, req_rx[0]}, {2'b00, 2'b01, e});
      end
      cyc();
    end
    rx_valid = 1'b0;
    #1;
    checks++;
    if ({req_trans_ready, busy} !== 3'b100) begin
      failures++; $display("FAIL blk_next_accept got=%b want=100", {req_trans_ready, busy});
    end
    cyc();
    req_trans_valid = '0;
    trans_ready = 1'b1;
    #1;
    checks++;
    if ({grant, trans, trans_cs} !== {1'b1, t1, 2'b10}) begin
      failures++; $display("FAIL blk_grant1 got=%h want=%h", {grant, trans, trans_cs}, {1'b1, t1, 2'b10});
    end
    cyc();
    trans_ready = 1'b0;
    rx = mk_rx(16'hC1C1, 1'b1, 1'b0);
    exp_rx_q.push_back(rx);
    rx_valid = 1'b1;
    #1;
    e = exp_rx_q.pop_front();
    checks++;
    if ({req_rx_valid, req_rx[1]} !== {2'b10, e}) begin
      failures++; $display("FAIL blk_req1_beat got=%h want=%h", {req_rx_valid, req_rx[1]}, {2'b10, e});
    end
    cyc();
    rx_valid = 1'b0;
    req_rx_ready = '0;
  endtask

  task automatic test_stray_beat();
    hyper_rx_t e;
    req_trans[0] = mk_tf(1'b1, 32'h0000_0500); req_cs[0] = 2'b01;
    req_trans_valid = 2'b01;
    #1;
    cyc();
    req_trans_valid = '0;
    trans_ready = 1'b1;
    cyc();
    trans_ready = 1'b0;
    rx = mk_rx(16'h5A5A, 1'b1, 1'b1);
    exp_rx_q.push_back(rx);
    rx_valid = 1'b1;
    req_rx_ready = 2'b11;
    req_tx[0] = mk_tx(16'h7777, 1'b1, 2'b11);
    req_tx_valid[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tx_ready = (c == 1);
      #1;
      checks++;
      if ({rx_ready, req_rx_valid} !== 3'b000) begin
        failures++; $display("FAIL stray_wdata cycle=%0d got=%b want=000", c, {rx_ready, req_rx_valid});
      end
      cyc();
    end
    req_tx_valid = '0;
    tx_ready = 1'b0;
    b_valid = 1'b1; req_b_ready = 2'b01;
    #1;
    checks++;
    if ({rx_ready, req_rx_valid, req_b_valid} !== 5'b00001) begin
      failures++; $display("FAIL stray_wresp got=%b want=00001", {rx_ready, req_rx_valid, req_b_valid});
    end
    cyc();
    b_valid = 1'b0; req_b_ready = '0;
    req_trans[0] = mk_tf(1'b0, 32'h0000_0600);
    req_trans_valid = 2'b01;
    #1;
    checks++;
    if ({rx_ready, req_rx_valid} !== 3'b000) begin
      failures++; $display("FAIL stray_idle got=%b want=000", {rx_ready, req_rx_valid});
    end
    cyc();
    req_trans_valid = '0;
    trans_ready = 1'b1;
    cyc();
    trans_ready = 1'b0;
    #1;
    e = exp_rx_q.pop_front();
    checks++;
    if ({req_rx_valid, rx_ready, req_rx[0]} !== {2'b01, 1'b1, e}) begin
      failures++; $display("FAIL stray_deliver got=%h want=%h", {req_rx_valid, rx_ready, req_rx[0]}, {2'b01, 1'b1, e});
    end
    cyc();
    rx_valid = 1'b0;
    req_rx_ready = '0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL stray_busy_fall got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    hyper_tf_t t;
    req_trans[1] = mk_tf(1'b1, 32'h0000_0700); req_cs[1] = 2'b10;
    req_trans_valid = 2'b10;
    #1;
    cyc();
    req_trans_valid = '0;
    trans_ready = 1'b1;
    cyc();
    trans_ready = 1'b0;
    req_tx[1] = mk_tx(16'h9999, 1'b0, 2'b11);
    req_tx_valid[1] = 1'b1;
    #1;
    checks++;
    if ({tx_valid, grant} !== 2'b11) begin
      failures++; $display("FAIL rstmid_wdata got=%b want=11", {tx_valid, grant});
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, grant, tx_valid, req_tx_ready, trans_valid} !== 6'b0) begin
      failures++; $display("FAIL rstmid_ctrl got=%b want=000000", {busy, grant, tx_valid, req_tx_ready, trans_valid});
    end
    checks++;
    if ({trans, trans_cs, tx} !== '0) begin
      failures++; $display("FAIL rstmid_data got=%h want=0", {trans, trans_cs, tx});
    end
    req_tx_valid = '0;
    t = mk_tf(1'b0, 32'h0000_0800);
    req_trans[1] = t;
    req_trans_valid = 2'b10;
    #1;
    checks++;
    if (req_trans_ready !== 2'b10) begin
      failures++; $display("FAIL rstmid_accept got=%b want=10", req_trans_ready);
    end
    cyc();
    req_trans_valid = '0;
    trans_ready = 1'b1;
    #1;
    checks++;
    if ({grant, trans_valid, trans} !== {1'b1, 1'b1, t}) begin
      failures++; $display("FAIL rstmid_issue got=%h want=%h", {grant, trans_valid, trans}, {1'b1, 1'b1, t});
    end
    cyc();
    trans_ready = 1'b0;
    rx = mk_rx(16'h8888, 1'b1, 1'b0);
    rx_valid = 1'b1;
    req_rx_ready = 2'b10;
    #1;
    checks++;
    if (req_rx_valid !== 2'b10) begin
      failures++; $display("FAIL rstmid_rdata got=%b want=10", req_rx_valid);
    end
    cyc();
    rx_valid = 1'b0;
    req_rx_ready = '0;
  endtask

  task automatic test_contention();
    logic [0:0] e;
`ifdef HYPERBUS_ARB_RR_EN
    exp_gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_gnt_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    req_trans[0] = mk_tf(1'b0, 32'h0000_0900); req_cs[0] = 2'b01;
    req_trans[1] = mk_tf(1'b0, 32'h0000_0A00); req_cs[1] = 2'b10;
    req_trans_valid = 2'b11;
    trans_ready = 1'b1;
    rx = mk_rx(16'h4242, 1'b1, 1'b0);
    rx_valid = 1'b1;
    req_rx_ready = 2'b11;
    for (int n = 0; n < 4; n++) begin
      e = exp_gnt_q.pop_front();
      #1;
      checks++;
      if (req_trans_ready !== (2'b01 << e)) begin
        failures++; $display("FAIL cont_ready txn=%0d got=%b want=%b", n, req_trans_ready, 2'b01 << e);
      end
      cyc();
      checks++;
      if (grant !== e) begin
        failures++; $display("FAIL cont_grant txn=%0d got=%0d want=%0d", n, grant, e);
      end
      cyc();
      cyc();
    end
    req_trans_valid = '0;
    trans_ready = 1'b0;
    rx_valid = 1'b0;
    req_rx_ready = '0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NR; k++) begin
      req_trans[k] = '0;
      req_cs[k]    = '0;
      req_tx[k]    = '0;
    end
    req_trans_valid = '0; req_tx_valid = '0; req_rx_ready = '0; req_b_ready = '0;
    trans_ready = 1'b0; tx_ready = 1'b0;
    rx = '0; rx_valid = 1'b0;
    b_error = 1'b0; b_valid = 1'b0;

    test_reset();
    test_single_read();
    test_write_bp();
    test_blocking();
    test_stray_beat();
    test_reset_mid();
    test_contention();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
